// File: rtl/lamp_sequencer.sv
// lamp_sequencer
// Clocked controller for a three-way hall lamp. Any one of three wall
// switches toggles the lamp. Each raw switch is synchronised and
// debounced. Debounced edges are combined by parity into toggle events.
// These drive an OFF / ON / WARN state machine. An optional auto-off
// timer is included, and the lamp blinks as a warning before it turns
// itself off.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst         asynchronous, active-high reset (clears every flop)
//   S1, S2, S3  raw wall switches, asynchronous to clk
//   timeout_en  1 = auto-off timer active (synchronous to clk)
//   F           registered lamp drive
//   state       FSM state: 00 = OFF, 01 = ON, 10 = WARN
//   toggle      one-cycle pulse for each accepted toggle event

module lamp_sequencer #(
    parameter int DB_CYCLES   = 4,
    parameter int TIMEOUT     = 64,
    parameter int WARN_CYCLES = 16,
    parameter int BLINK_HALF  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    input  logic       timeout_en,
    output logic       F,
    output logic [1:0] state,
    output logic       toggle
);

    // Counter widths. A parameter of 1 still needs a one-bit counter.
    localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TO_W    = $clog2(TIMEOUT);
    localparam int WN_W    = $clog2(WARN_CYCLES);
    localparam int TIMER_W = (TO_W > WN_W) ? TO_W : WN_W;
    localparam int BL_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ON_LAST    = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] WARN_LAST  = TIMER_W'(WARN_CYCLES - 1);
    localparam logic [BL_W-1:0]    BLINK_LAST = BL_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_ON   = 2'b01,
        ST_WARN = 2'b10
    } state_t;

    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      db;
    logic [2:0]      db_prev;
    logic [DB_W-1:0] cnt [3];
    logic            toggle_event;

    state_t              cur_state;
    state_t              next_state;
    logic [TIMER_W-1:0]  timer;
    logic [TIMER_W-1:0]  timer_next;
    logic [BL_W-1:0]     blink;
    logic [BL_W-1:0]     blink_next;
    logic                f_next;

    assign raw = {S3, S2, S1};

    // Two-flop synchroniser, then a debounce counter for each switch.
    // The counter runs while the synchronised value differs from the
    // debounced value. It restarts whenever they agree again. db takes
    // the new value on the cycle the count would reach DB_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != db[i]) begin
                    if (cnt[i] == DB_LAST) begin
                        db[i]  <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + DB_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // An odd number of simultaneous debounced edges gives one toggle.
    // An even number cancels out, just as it does in parity lamp wiring.
    assign toggle_event = ^(db ^ db_prev);

    // State, timer, blink counter, lamp and toggle pulse all update on
    // the same edge, so toggle and the new state appear together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_OFF;
            timer     <= '0;
            blink     <= '0;
            F         <= 1'b0;
            toggle    <= 1'b0;
        end else begin
            cur_state <= next_state;
            timer     <= timer_next;
            blink     <= blink_next;
            F         <= f_next;
            toggle    <= toggle_event;
        end
    end

    // Next-state logic. A toggle has the highest priority. Dropping
    // timeout_en comes next, and timer expiry comes last. In WARN a
    // toggle re-arms the lamp rather than switching it off. The timer is
    // reloaded on every state change, so it never has to wrap.
    always_comb begin
        next_state = cur_state;
        timer_next = timer;
        blink_next = blink;
        f_next     = F;
        case (cur_state)
            ST_OFF: begin
                timer_next = '0;
                blink_next = '0;
                f_next     = 1'b0;
                if (toggle_event) begin
                    next_state = ST_ON;
                    f_next     = 1'b1;
                end
            end
            ST_ON: begin
                blink_next = '0;
                f_next     = 1'b1;
                if (toggle_event) begin
                    next_state = ST_OFF;
                    timer_next = '0;
                    f_next     = 1'b0;
                end else if (!timeout_en) begin
                    timer_next = '0;
                end else if (timer == ON_LAST) begin
                    next_state = ST_WARN;
                    timer_next = '0;
                    f_next     = 1'b0;
                end else begin
                    timer_next = timer + TIMER_W'(1);
                end
            end
            ST_WARN: begin
                if (toggle_event || !timeout_en) begin
                    next_state = ST_ON;
                    timer_next = '0;
                    blink_next = '0;
                    f_next     = 1'b1;
                end else if (timer == WARN_LAST) begin
                    next_state = ST_OFF;
                    timer_next = '0;
                    blink_next = '0;
                    f_next     = 1'b0;
                end else begin
                    // F starts low on entry and flips every BLINK_HALF cycles.
                    timer_next = timer + TIMER_W'(1);
                    if (blink == BLINK_LAST) begin
                        blink_next = '0;
                        f_next     = ~F;
                    end else begin
                        blink_next = blink + BL_W'(1);
                    end
                end
            end
            default: begin
                next_state = ST_OFF;
                timer_next = '0;
                blink_next = '0;
                f_next     = 1'b0;
            end
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_lamp_sequencer.sv
// tb_lamp_sequencer
// Scoreboard bench for lamp_sequencer. Each switch change that should
// toggle the lamp pushes the expected state, F and arrival cycle into a
// queue. A monitor pops one entry on every toggle pulse the DUT raises.
// Timer, blink and reset behaviour are checked directly against
// hand-computed values.

module tb_lamp_sequencer;

    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_ON   = 2'b01;
    localparam logic [1:0] ST_WARN = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic       S1;
    logic       S2;
    logic       S3;
    logic       timeout_en;
    logic       F;
    logic [1:0] state;
    logic       toggle;

    typedef struct {
        logic [1:0] st;
        logic       f;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    lamp_sequencer #(
        .DB_CYCLES  (4),
        .TIMEOUT    (64),
        .WARN_CYCLES(16),
        .BLINK_HALF (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .S1        (S1),
        .S2        (S2),
        .S3        (S3),
        .timeout_en(timeout_en),
        .F         (F),
        .state     (state),
        .toggle    (toggle)
    );

    // 10 ns clock. Rising edges are counted so that toggle latency can be
    // checked exactly.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: every toggle pulse must match the oldest expected event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && toggle) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_toggle: got toggle=1 at cycle %0d, required no toggle", cycle);
            end else begin
                e = exp_q.pop_front();
                if (state !== e.st || F !== e.f || cycle != e.cyc) begin
                    failures++;
                    $display("[TB] FAIL toggle_event: got state=%b F=%b cycle=%0d, required state=%b F=%b cycle=%0d",
                             state, F, cycle, e.st, e.f, e.cyc);
                end
            end
        end
    end

    // Call at a falling edge. A raw change made here is first sampled on
    // the next rising edge, so toggle appears 7 rising edges later.
    task automatic applyStimulus(input logic s1, input logic s2, input logic s3,
                                 input logic expect_toggle,
                                 input logic [1:0] est, input logic ef);
        S1 = s1;
        S2 = s2;
        S3 = s3;
        if (expect_toggle) exp_q.push_back('{st: est, f: ef, cyc: cycle + 7});
    endtask

    task automatic checkOutput(input string name, input logic [1:0] est, input logic ef);
        checks++;
        if (state !== est || F !== ef) begin
            failures++;
            $display("[TB] FAIL %s: got state=%b F=%b, required state=%b F=%b", name, state, F, est, ef);
        end
    endtask

    task automatic checkIdle(input string name);
        checks++;
        if (toggle !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s: got toggle=%b, required toggle=0", name, toggle);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        S1 = 1'b0;
        S2 = 1'b0;
        S3 = 1'b0;
        timeout_en = 1'b0;
        waitCycles(3);
        checkOutput("reset_state", ST_OFF, 1'b0);
        checkIdle("reset_toggle");
        rst = 1'b0;
        waitCycles(12);
        checkOutput("post_reset_idle", ST_OFF, 1'b0);

        // Single switch on, then a second switch off
        applyStimulus(1, 0, 0, 1, ST_ON, 1'b1);
        waitCycles(7);
        checkOutput("s1_on_latency", ST_ON, 1'b1);
        waitCycles(5);
        applyStimulus(1, 1, 0, 1, ST_OFF, 1'b0);
        waitCycles(12);
        checkOutput("s2_off", ST_OFF, 1'b0);

        // 3-cycle glitch is filtered; a 4-cycle pulse toggles twice
        applyStimulus(1, 1, 1, 0, ST_OFF, 1'b0);
        waitCycles(3);
        applyStimulus(1, 1, 0, 0, ST_OFF, 1'b0);
        waitCycles(12);
        checkOutput("glitch3_ignored", ST_OFF, 1'b0);
        applyStimulus(1, 1, 1, 1, ST_ON, 1'b1);
        waitCycles(4);
        applyStimulus(1, 1, 0, 1, ST_OFF, 1'b0);
        waitCycles(3);
        checkOutput("pulse4_rise_on", ST_ON, 1'b1);
        waitCycles(10);
        checkOutput("pulse4_back_off", ST_OFF, 1'b0);

        // Simultaneous edges: pairs cancel, three give one toggle
        applyStimulus(0, 0, 0, 0, ST_OFF, 1'b0);
        waitCycles(12);
        checkOutput("pair_fall_cancel", ST_OFF, 1'b0);
        applyStimulus(1, 1, 0, 0, ST_OFF, 1'b0);
        waitCycles(12);
        checkOutput("pair_rise_cancel", ST_OFF, 1'b0);
        applyStimulus(0, 0, 0, 0, ST_OFF, 1'b0);
        waitCycles(12);
        applyStimulus(1, 1, 1, 1, ST_ON, 1'b1);
        waitCycles(12);
        checkOutput("triple_rise_on", ST_ON, 1'b1);

        // Auto-off: 64 cycles ON, 16 cycles WARN blinking, then OFF
        applyStimulus(1, 1, 0, 1, ST_OFF, 1'b0);
        waitCycles(12);
        timeout_en = 1'b1;
        waitCycles(2);
        applyStimulus(1, 1, 1, 1, ST_ON, 1'b1);
        waitCycles(7);
        for (int i = 0; i < 64; i++) begin
            checkOutput("timeout_on_hold", ST_ON, 1'b1);
            waitCycles(1);
        end
        for (int i = 0; i < 16; i++) begin
            checkOutput("warn_blink", ST_WARN, logic'((i / 2) % 2));
            waitCycles(1);
        end
        checkOutput("warn_expired_off", ST_OFF, 1'b0);

        // Toggle in WARN re-arms a full timeout; dropping timeout_en leaves WARN
        waitCycles(2);
        applyStimulus(1, 0, 1, 1, ST_ON, 1'b1);
        waitCycles(71);
        checkOutput("warn_entry", ST_WARN, 1'b0);
        applyStimulus(1, 1, 1, 1, ST_ON, 1'b1);
        waitCycles(7);
        for (int i = 0; i < 64; i++) begin
            checkOutput("rearm_full_timeout", ST_ON, 1'b1);
            waitCycles(1);
        end
        checkOutput("rearm_warn_again", ST_WARN, 1'b0);
        timeout_en = 1'b0;
        waitCycles(1);
        checkOutput("te_drop_on", ST_ON, 1'b1);
        waitCycles(5);
        checkOutput("te_off_timer_held", ST_ON, 1'b1);

        // Get to ON with an even number of switches high, then reset mid-WARN
        timeout_en = 1'b1;
        waitCycles(81);
        checkOutput("auto_off", ST_OFF, 1'b0);
        applyStimulus(1, 1, 0, 1, ST_ON, 1'b1);
        waitCycles(73);
        checkOutput("pre_reset_warn", ST_WARN, 1'b1);
        #3 rst = 1'b1;
        #1;
        checkOutput("async_reset", ST_OFF, 1'b0);
        checkIdle("async_reset_toggle");
        waitCycles(2);
        rst = 1'b0;
        waitCycles(20);
        checkOutput("post_release_off", ST_OFF, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL missing_toggles: got %0d expected events outstanding, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
